// File: rtl/alt_vipcti131_common_avalon_mm_pkg.sv
// Shared definitions for the VIP Avalon-MM masters: FSM state encoding and a
// constant-foldable ceil(log2) used to size pointers and counters.
package alt_vipcti131_common_avalon_mm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_REQ   = 2'd1,
        WR_BURST = 2'd2
    } split_state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned p = 1; p < value; p = p << 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/alt_vipcti131_common_avalon_mm_split_master_if.sv
// Command, write-data, read-data and Avalon-MM master signals of the split master.
// The master modport is the block's view; slave is the surrounding environment.
interface alt_vipcti131_common_avalon_mm_split_master_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned LEN_WIDTH   = 16,
    parameter int unsigned BURST_WIDTH = 6
);
    localparam int unsigned BYTES = DATA_WIDTH / 8;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [ADDR_WIDTH-1:0]  cmd_addr;
    logic [LEN_WIDTH-1:0]   cmd_len;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [DATA_WIDTH-1:0]  wr_data;
    logic                   rd_valid;
    logic                   rd_ready;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   busy;
    logic [ADDR_WIDTH-1:0]  av_address;
    logic [BURST_WIDTH-1:0] av_burstcount;
    logic [DATA_WIDTH-1:0]  av_writedata;
    logic [BYTES-1:0]       av_byteenable;
    logic                   av_write;
    logic                   av_read;
    logic [DATA_WIDTH-1:0]  av_readdata;
    logic                   av_readdatavalid;
    logic                   av_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready,
        input  av_readdata, av_readdatavalid, av_waitrequest,
        output cmd_ready, wr_ready, rd_valid, rd_data, busy,
        output av_address, av_burstcount, av_writedata, av_byteenable, av_write, av_read
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready,
        output av_readdata, av_readdatavalid, av_waitrequest,
        input  cmd_ready, wr_ready, rd_valid, rd_data, busy,
        input  av_address, av_burstcount, av_writedata, av_byteenable, av_write, av_read
    );

endinterface

// File: rtl/alt_vipcti131_common_sync_fifo.sv
// Single-clock show-ahead FIFO with used-word count; head word is visible on
// pop_data whenever empty is low.
module alt_vipcti131_common_sync_fifo
    import alt_vipcti131_common_avalon_mm_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [AW:0]      used
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             pop_ok;

    assign empty    = (used == '0);
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rptr];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    // Simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            used <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop_ok) begin
                rptr <= rptr + AW'(1);
            end
            used <= used + (push ? (AW+1)'(1) : (AW+1)'(0)) - (pop_ok ? (AW+1)'(1) : (AW+1)'(0));
        end
    end

endmodule

// File: rtl/alt_vipcti131_common_avalon_mm_split_master.sv
// Avalon-MM master that splits one arbitrary-length command into window-aligned
// bursts; reads are credit-limited so the read-data FIFO can never overflow.
module alt_vipcti131_common_avalon_mm_split_master
    import alt_vipcti131_common_avalon_mm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned LEN_WIDTH        = 16,
    parameter int unsigned BURST_WIDTH      = 6,
    parameter int unsigned MAX_BURST        = 32,
    parameter int unsigned RDATA_FIFO_DEPTH = 64
) (
    input logic clock,
    input logic reset,
    alt_vipcti131_common_avalon_mm_split_master_if.master bus
);

    localparam int unsigned BYTES    = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB = clog2(BYTES);
    localparam int unsigned BW       = LEN_WIDTH + 1;
    localparam int unsigned PW       = clog2(RDATA_FIFO_DEPTH) + 1;

    split_state_t          state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [BW-1:0]         rem;
    logic [BW-1:0]         next_rem;
    logic [BW-1:0]         bsz;
    logic [BW-1:0]         beat_cnt;
    logic                  av_read_q;
    logic [PW-1:0]         pending;
    logic [PW-1:0]         credit;
    logic [PW-1:0]         rd_used;
    logic                  rd_empty;
    logic                  rd_push;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  last_beat;
    logic                  burst_done;
    logic                  credit_ok;

    // Largest burst that fits the remaining length and stays inside the current window.
    function automatic logic [BW-1:0] calc_bsz(input logic [ADDR_WIDTH-1:0] a,
                                               input logic [BW-1:0]         remaining);
        logic [ADDR_WIDTH-1:0] word_off;
        logic [BW-1:0]         room;
        word_off = (a >> ADDR_LSB) & ADDR_WIDTH'(MAX_BURST - 1);
        room     = BW'(MAX_BURST) - BW'(word_off);
        return (remaining < room) ? remaining : room;
    endfunction

    assign next_addr  = addr + (ADDR_WIDTH'(bsz) << ADDR_LSB);
    assign next_rem   = rem - bsz;
    assign credit     = PW'(RDATA_FIFO_DEPTH) - rd_used - pending;
    assign credit_ok  = (credit >= PW'(bsz));
    assign rd_accept  = (state == RD_REQ) && av_read_q && !bus.av_waitrequest;
    assign wr_accept  = (state == WR_BURST) && bus.wr_valid && !bus.av_waitrequest;
    assign last_beat  = (beat_cnt == bsz - BW'(1));
    assign burst_done = rd_accept || (wr_accept && last_beat);
    assign rd_push    = bus.av_readdatavalid && (pending != '0);

    // av_read is re-armed one cycle after each accept so the credit check sees the updated pending count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            bsz       <= '0;
            beat_cnt  <= '0;
            av_read_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        addr     <= bus.cmd_addr;
                        rem      <= BW'(bus.cmd_len);
                        bsz      <= calc_bsz(bus.cmd_addr, BW'(bus.cmd_len));
                        beat_cnt <= '0;
                        if (bus.cmd_len != '0) begin
                            state <= bus.cmd_write ? WR_BURST : RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (!av_read_q) begin
                        av_read_q <= credit_ok;
                    end else if (!bus.av_waitrequest) begin
                        av_read_q <= 1'b0;
                    end
                end
                WR_BURST: begin
                    if (wr_accept) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            if (burst_done) begin
                addr <= next_addr;
                rem  <= next_rem;
                bsz  <= calc_bsz(next_addr, next_rem);
                if (next_rem == '0) begin
                    state <= IDLE;
                end
            end
        end
    end

    // Outstanding read beats: net of burst accepts and returned beats.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending + (rd_accept ? PW'(bsz) : PW'(0)) - (rd_push ? PW'(1) : PW'(0));
        end
    end

    alt_vipcti131_common_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RDATA_FIFO_DEPTH)
    ) u_rdata_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (rd_push),
        .push_data (bus.av_readdata),
        .pop       (bus.rd_ready),
        .pop_data  (bus.rd_data),
        .empty     (rd_empty),
        .used      (rd_used)
    );

    assign bus.cmd_ready     = (state == IDLE);
    assign bus.wr_ready      = (state == WR_BURST) && !bus.av_waitrequest;
    assign bus.av_write      = (state == WR_BURST) && bus.wr_valid;
    assign bus.av_writedata  = bus.wr_data;
    assign bus.av_read       = av_read_q;
    assign bus.av_address    = addr;
    assign bus.av_burstcount = BURST_WIDTH'(bsz);
    assign bus.av_byteenable = '1;
    assign bus.rd_valid      = !rd_empty;
    assign bus.busy          = (state != IDLE) || (pending != '0) || !rd_empty;

endmodule

// File: tb/tb_alt_vipcti131_common_avalon_mm_split_master.sv
// Directed bench for the split master: an Avalon slave model records bursts and
// beats, and the main sequence compares them against hand-computed expectations.
module tb_alt_vipcti131_common_avalon_mm_split_master;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    alt_vipcti131_common_avalon_mm_split_master_if bus ();

    alt_vipcti131_common_avalon_mm_split_master dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Environment mode flags, written only by the main sequence.
    bit wait_rand = 1'b0;
    bit wr_mode   = 1'b0;
    bit rd_hold   = 1'b0;
    int stray_req = 0;

    // Slave-model records, written only by the slave process.
    logic [31:0] rb_addr [$];
    int          rb_bc   [$];
    logic [31:0] wb_addr [$];
    int          wb_bc   [$];
    logic [63:0] wb_data [$];
    logic [63:0] rd_words[$];
    int          ret_q   [$];
    int wr_total       = 0;
    int issued_total   = 0;
    int consumed_total = 0;
    int max_out        = 0;
    int rd_cycles      = 0;
    int wr_cycles      = 0;
    int busy_cycles    = 0;
    int both_cycles    = 0;
    int stray_done     = 0;

    function automatic logic [63:0] rpat(input int w);
        return {16'hDA7A, w[15:0], ~w};
    endfunction

    function automatic logic [63:0] wpat(input int i);
        int k;
        k = i * 7 + 3;
        return {16'h5EED, i[15:0], k};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Avalon slave, write source and read sink; inputs change on the falling edge.
    always @(negedge clock) begin
        if (reset) begin
            ret_q.delete();
            bus.av_waitrequest   = 1'b0;
            bus.av_readdatavalid = 1'b0;
            bus.av_readdata      = '0;
            bus.wr_valid         = 1'b0;
            bus.wr_data          = '0;
            bus.rd_ready         = 1'b0;
        end else begin
            bus.av_waitrequest = wait_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (stray_req != stray_done) begin
                stray_done++;
                bus.av_readdatavalid = 1'b1;
                bus.av_readdata      = 64'hBAD0_BAD0_BAD0_BAD0;
            end else if (ret_q.size() != 0 && !(wait_rand && $urandom_range(0, 2) == 0)) begin
                bus.av_readdatavalid = 1'b1;
                bus.av_readdata      = rpat(ret_q.pop_front());
            end else begin
                bus.av_readdatavalid = 1'b0;
            end
            bus.wr_valid = wr_mode && !(wait_rand && $urandom_range(0, 2) == 0);
            bus.wr_data  = wpat(wr_total);
            bus.rd_ready = !rd_hold;
        end
        #1;
        if (!reset) begin
            if (bus.av_read && !bus.av_waitrequest) begin
                rb_addr.push_back(bus.av_address);
                rb_bc.push_back(int'(bus.av_burstcount));
                for (int b = 0; b < int'(bus.av_burstcount); b++) begin
                    ret_q.push_back(int'(bus.av_address >> 3) + b);
                end
                issued_total += int'(bus.av_burstcount);
            end
            if (bus.av_write && !bus.av_waitrequest) begin
                wb_addr.push_back(bus.av_address);
                wb_bc.push_back(int'(bus.av_burstcount));
                wb_data.push_back(bus.av_writedata);
                wr_total++;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                rd_words.push_back(bus.rd_data);
                consumed_total++;
            end
            if (bus.av_read) rd_cycles++;
            if (bus.av_write) wr_cycles++;
            if (bus.busy) busy_cycles++;
            if (bus.av_read && bus.av_write) both_cycles++;
            if (issued_total - consumed_total > max_out) max_out = issued_total - consumed_total;
        end
    end

    task automatic send_cmd(input bit wr, input logic [31:0] a, input int len);
        int n;
        n = 0;
        @(negedge clock);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = 16'(len);
        #2;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clock);
            #2;
            n++;
        end
        check("cmd_accept", bus.cmd_ready, 1);
        @(negedge clock);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            #2;
            n++;
        end while (bus.busy && n < budget);
        check("idle_timeout", (n < budget), 1);
        repeat (3) @(negedge clock);
    endtask

    task automatic check_burst(input string tag, input int idx, input logic [31:0] a, input int bc);
        check($sformatf("%s_addr%0d", tag, idx), rb_addr[idx], a);
        check($sformatf("%s_bc%0d", tag, idx), rb_bc[idx], bc);
    endtask

    task automatic check_reads(input string tag, input int start, input int first_word, input int n);
        check($sformatf("%s_count", tag), rd_words.size() - start, n);
        for (int i = 0; i < n && start + i < rd_words.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), rd_words[start + i], rpat(first_word + i));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_wr_ready"}, bus.wr_ready, 0);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_av_read"}, bus.av_read, 0);
        check({tag, "_av_write"}, bus.av_write, 0);
        check({tag, "_av_address"}, bus.av_address, 0);
        check({tag, "_av_burstcount"}, bus.av_burstcount, 0);
    endtask

    initial begin
        int sb, sw, sr, si, a0, a1, a2, n;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        repeat (3) @(negedge clock);
        #2;
        check_reset_outputs("rst");
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: long read split at window boundaries
        sb = rb_addr.size(); sr = rd_words.size();
        send_cmd(1'b0, 32'h0, 70);
        wait_idle(1000);
        check("t1_bursts", rb_addr.size() - sb, 3);
        if (rb_addr.size() - sb == 3) begin
            check_burst("t1", sb,     32'h000, 32);
            check_burst("t1", sb + 1, 32'h100, 32);
            check_burst("t1", sb + 2, 32'h200, 6);
        end
        check_reads("t1", sr, 0, 70);

        // 2: unaligned start, first burst trimmed to the window edge
        sb = rb_addr.size(); sr = rd_words.size();
        send_cmd(1'b0, 32'hF0, 8);
        wait_idle(500);
        check("t2_bursts", rb_addr.size() - sb, 2);
        if (rb_addr.size() - sb == 2) begin
            check_burst("t2", sb,     32'h0F0, 2);
            check_burst("t2", sb + 1, 32'h100, 6);
        end
        check_reads("t2", sr, 30, 8);

        // 3: read with a stalled consumer, credit limits the outstanding words
        sb = rb_addr.size(); sr = rd_words.size(); si = issued_total;
        rd_hold = 1'b1;
        send_cmd(1'b0, 32'h1000, 200);
        repeat (120) @(negedge clock);
        #2;
        check("t3_issued_stalled", issued_total - si, 64);
        check("t3_consumed_stalled", rd_words.size() - sr, 0);
        check("t3_av_read_low", bus.av_read, 0);
        check("t3_busy", bus.busy, 1);
        rd_hold = 1'b0;
        wait_idle(3000);
        check("t3_bursts", rb_addr.size() - sb, 7);
        if (rb_addr.size() - sb == 7) begin
            check_burst("t3", sb + 2, 32'h1200, 32);
            check_burst("t3", sb + 6, 32'h1600, 8);
        end
        check("t3_max_outstanding", max_out, 64);
        check_reads("t3", sr, 512, 200);

        // 4: write with gappy data and random waitrequest
        sw = wb_addr.size(); a0 = wr_total; a1 = rd_cycles;
        wait_rand = 1'b1;
        wr_mode   = 1'b1;
        send_cmd(1'b1, 32'h40, 40);
        check("t4_byteenable", bus.av_byteenable, 8'hFF);
        wait_idle(2000);
        repeat (5) @(negedge clock);
        wr_mode   = 1'b0;
        wait_rand = 1'b0;
        check("t4_beats", wb_addr.size() - sw, 40);
        for (int i = 0; i < 40 && sw + i < wb_addr.size(); i++) begin
            check($sformatf("t4_addr%0d", i), wb_addr[sw + i], (i < 24) ? 32'h40 : 32'h100);
            check($sformatf("t4_bc%0d", i), wb_bc[sw + i], (i < 24) ? 24 : 16);
            check($sformatf("t4_data%0d", i), wb_data[sw + i], wpat(a0 + i));
        end
        check("t4_no_reads", rd_cycles - a1, 0);

        // 5: zero-length command
        a0 = rd_cycles; a1 = wr_cycles; a2 = busy_cycles;
        send_cmd(1'b0, 32'h80, 0);
        repeat (6) @(negedge clock);
        #2;
        check("t5_no_read", rd_cycles - a0, 0);
        check("t5_no_write", wr_cycles - a1, 0);
        check("t5_no_busy", busy_cycles - a2, 0);
        check("t5_cmd_ready", bus.cmd_ready, 1);

        // 6: reset in the middle of a write burst, then a clean read
        sw = wr_total;
        wr_mode = 1'b1;
        send_cmd(1'b1, 32'h0, 64);
        n = 0;
        while (wr_total - sw < 5 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("t6_reach_beat5", (n < 200), 1);
        @(negedge clock);
        reset = 1'b1;
        #2;
        check_reset_outputs("t6_rst");
        wr_mode = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        sb = rb_addr.size(); sr = rd_words.size();
        send_cmd(1'b0, 32'h300, 10);
        wait_idle(500);
        check("t6_bursts", rb_addr.size() - sb, 1);
        if (rb_addr.size() - sb == 1) begin
            check_burst("t6", sb, 32'h300, 10);
        end
        check_reads("t6", sr, 96, 10);

        // Stray read beat with nothing outstanding is dropped
        sr = rd_words.size();
        stray_req++;
        repeat (5) @(negedge clock);
        #2;
        check("stray_dropped", rd_words.size() - sr, 0);
        check("stray_rd_valid", bus.rd_valid, 0);
        check("never_rd_and_wr", both_cycles, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
